// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared constants, types and mod-26 helpers for the rotor
package enigma_pkg;

  localparam int ALPHA   = 26;
  localparam int ASCII_A = 65;

  typedef logic [4:0] letter_t;

  typedef enum logic [1:0] {
    IDLE,
    SRCH,
    DONE
  } state_t;

  // (a + b) mod 26 for a, b in 0..25, using a 6-bit intermediate
  function automatic letter_t add26(input letter_t a, input letter_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ALPHA)) s = s - 6'(ALPHA);
    return s[4:0];
  endfunction

  // (a - b) mod 26 for a, b in 0..25; bit 5 flags a negative difference
  function automatic letter_t sub26(input letter_t a, input letter_t b);
    logic [5:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[5]) d = d + 6'(ALPHA);
    return d[4:0];
  endfunction

  // Entry k lives at tbl[200-8k +: 8]; shifting left by 8k brings it to the top byte
  function automatic logic [7:0] wiring_entry(input logic [207:0] tbl, input letter_t k);
    logic [207:0] t;
    t = tbl << {k, 3'b000};
    return t[207:200];
  endfunction

  // ASCII letter to 0..25 (only meaningful for 'A'..'Z')
  function automatic letter_t to_letter(input logic [7:0] c);
    logic [7:0] t;
    t = c - 8'(ASCII_A);
    return t[4:0];
  endfunction

  function automatic logic [7:0] to_ascii(input letter_t l);
    return {3'b000, l} + 8'(ASCII_A);
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

endpackage

// File: rtl/enigma_rotor_if.sv
// rtl/enigma_rotor_if.sv - rotor control/data bundle; ring_in exists only with ROTOR_RING_EN
interface enigma_rotor_if;
  logic         set;
  logic [207:0] idx_in;
  logic [4:0]   pos_in;
  logic [4:0]   notch_in;
`ifdef ROTOR_RING_EN
  logic [4:0]   ring_in;
`endif
  logic         step;
  logic         valid;
  logic [7:0]   din;
  logic         dec;
  logic [7:0]   dout;
  logic         done;
  logic         busy;
  logic         carry;
  logic [4:0]   pos;
  logic         err;

  modport master (
    output set, idx_in, pos_in, notch_in,
`ifdef ROTOR_RING_EN
    output ring_in,
`endif
    output step, valid, din, dec,
    input  dout, done, busy, carry, pos, err
  );

  modport slave (
    input  set, idx_in, pos_in, notch_in,
`ifdef ROTOR_RING_EN
    input  ring_in,
`endif
    input  step, valid, din, dec,
    output dout, done, busy, carry, pos, err
  );
endinterface

// File: rtl/enigma_wiring_mux.sv
// rtl/enigma_wiring_mux.sv - 26:1 byte select from the wiring table
module enigma_wiring_mux
  import enigma_pkg::*;
(
  input  logic [207:0] tbl_i,
  input  letter_t      sel_i,
  output logic [7:0]   byte_o
);

  // Out-of-range indices read as zero so they never match a letter
  always_comb begin
    byte_o = 8'h00;
    if (sel_i < 5'(ALPHA)) byte_o = wiring_entry(tbl_i, sel_i);
  end

endmodule

// File: rtl/enigma_rotor.sv
// rtl/enigma_rotor.sv - single Enigma rotor stage; ROTOR_RING_EN adds a ring setting
module enigma_rotor
  import enigma_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  enigma_rotor_if.slave  rif
);

  state_t       state_q;
  logic [207:0] tbl_q;
  letter_t      pos_q;
  letter_t      notch_q;
  letter_t      j_q;
  logic         pend_q;
  logic [7:0]   din_q;
  logic         dec_q;
  logic [7:0]   dout_q;
  logic         done_q;
  logic         busy_q;
  logic         carry_q;
  logic         err_q;

  letter_t      ring_w;
  letter_t      off_d;
  letter_t      e_d;
  letter_t      sel_d;
  letter_t      w_d;
  letter_t      pos_d;
  letter_t      j_d;
  logic [7:0]   mux_byte;

`ifdef ROTOR_RING_EN
  letter_t      ring_q;
  assign ring_w = ring_q;
`else
  assign ring_w = '0;
`endif

  // Effective offset, entry index and shared table index for this search step
  always_comb begin
    off_d = sub26(pos_q, ring_w);
    e_d   = add26(to_letter(din_q), off_d);
    sel_d = dec_q ? j_q : e_d;
    w_d   = to_letter(mux_byte);
    pos_d = (pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1;
    j_d   = j_q + 5'd1;
  end

  enigma_wiring_mux u_mux (
    .tbl_i  (tbl_q),
    .sel_i  (sel_d),
    .byte_o (mux_byte)
  );

  // Control FSM: set overrides everything; steps only land in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tbl_q   <= '0;
      pos_q   <= '0;
      notch_q <= '0;
      j_q     <= '0;
      pend_q  <= 1'b0;
      din_q   <= '0;
      dec_q   <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef ROTOR_RING_EN
      ring_q  <= '0;
`endif
    end else begin
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      if (rif.set) begin
        tbl_q   <= rif.idx_in;
        pos_q   <= rif.pos_in;
        notch_q <= rif.notch_in;
`ifdef ROTOR_RING_EN
        ring_q  <= rif.ring_in;
`endif
        pend_q  <= 1'b0;
        err_q   <= 1'b0;
        busy_q  <= 1'b0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rif.step || pend_q) begin
              pos_q   <= pos_d;
              carry_q <= (pos_q == notch_q);
              pend_q  <= 1'b0;
            end
            if (rif.valid) begin
              din_q   <= rif.din;
              dec_q   <= rif.dec;
              j_q     <= '0;
              busy_q  <= 1'b1;
              state_q <= SRCH;
            end
          end
          SRCH: begin
            if (rif.step) pend_q <= 1'b1;
            if (!is_letter(din_q)) begin
              dout_q  <= din_q;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (!dec_q) begin
              dout_q  <= to_ascii(sub26(w_d, off_d));
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (w_d == e_d) begin
              dout_q  <= to_ascii(sub26(j_q, off_d));
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (j_q == 5'd25) begin
              dout_q  <= 8'h3F;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              j_q <= j_d;
            end
          end
          DONE: begin
            if (rif.step) pend_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign rif.dout  = dout_q;
  assign rif.done  = done_q;
  assign rif.busy  = busy_q;
  assign rif.carry = carry_q;
  assign rif.pos   = pos_q;
  assign rif.err   = err_q;

endmodule

// File: doc/enigma_rotor.md
Name: enigma_rotor

Overview:
- Single Enigma rotor stage; sits directly upstream of the reflector on the forward path and consumes its output on the return path.
- Holds a 26-letter wiring table, a rotor position and a turnover notch.
- Substitutes one ASCII letter per valid/done handshake: forward through the wiring when dec=0, inverse when dec=1.
- Steps on request and emits a carry pulse to drive the next rotor.

Parameters:
- ALPHA, 26, alphabet size.
- ASCII_A, 65, code of 'A'.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- set  in  1  load wiring, position and notch.
- idx_in  in  208  wiring table; entry k at idx_in[200-8k +: 8], ASCII 'A'..'Z'.
- pos_in  in  5  start position 0..25, loaded on set.
- notch_in  in  5  turnover position 0..25, loaded on set.
- step  in  1  advance position by one.
- valid  in  1  din is a request.
- din  in  8  ASCII input letter.
- dec  in  1  0 = forward lookup, 1 = inverse lookup; sampled with valid.
- dout  out  8  ASCII result.
- done  out  1  one-cycle pulse; dout valid.
- busy  out  1  high while in SRCH or DONE.
- carry  out  1  one-cycle pulse on notch turnover.
- pos  out  5  current position.
- err  out  1  sticky; set when an inverse search fails.

Behaviour:
- Reset values: dout=0, done=0, busy=0, carry=0, pos=0, err=0, wiring table all 0, notch=0, state IDLE.
- Definitions: x = din-ASCII_A; e = (x+pos) mod 26; W[k] = wiring entry k minus ASCII_A.
- Mod-26 arithmetic:
  - Use 6-bit intermediates.
  - Subtract 26 if the sum is >=26; add 26 if the difference is negative.
  - No division or modulo operators.
- FSM states: IDLE, SRCH, DONE.
  - IDLE and valid: latch din and dec; clear search counter j; go to SRCH.
  - SRCH, dec=0: dout <= ((W[e]-pos) mod 26)+ASCII_A; go to DONE.
  - SRCH, dec=1: if W[j]==e, dout <= ((j-pos) mod 26)+ASCII_A and go to DONE.
    - Else if j==25: dout <= 8'h3F, set err, go to DONE.
    - Else j <= j+1.
  - DONE: done=1 for exactly this cycle; go to IDLE. dout holds until the next result.
- Latency:
  - Forward: done asserted 2 cycles after the valid edge.
  - Inverse: 2+m cycles, where m is the matched index; 27 cycles worst case.
- din outside 'A'..'Z': passed through unchanged to dout, 2-cycle latency, no table access.
- valid while busy: ignored, not queued.
- Step:
  - Accepted only in IDLE: pos <= (pos==25) ? 0 : pos+1.
  - A step during busy sets a pending flag; the step is applied on the first IDLE cycle.
  - At most one step is pending; further steps while pending are dropped.
  - Step and valid in the same IDLE cycle: the step is applied first, and the request uses the new pos.
- Carry: pulses the cycle after pos advances away from a position equal to notch.
- Set:
  - Highest priority: loads table, pos, notch.
  - Clears pending step and err.
  - Aborts any operation: returns to IDLE, no done.
- Reset asserted mid-operation: immediate return to reset values; no done.

Optional Feature:
- Macro: ROTOR_RING_EN.
- Defined:
  - Adds port ring_in (in, 5), latched on set.
  - Effective offset becomes (pos-ring) mod 26 in all lookups.
  - Notch comparison still uses pos.
- Undefined: no port; ring is treated as 0.

Decomposition:
- Package enigma_pkg:
  - ALPHA and ASCII_A constants.
  - letter_t (5-bit) typedef.
  - add26/sub26 functions.
  - Wiring slice function returning entry k of a 208-bit table.
  - FSM state enum.
- Sub-module: enigma_wiring_mux, a combinational 26:1 byte select from the table by index, instanced once and shared by forward lookup and inverse search.

Test Plan:
- Forward at pos 0:
  - Stimulus: set wiring "EKMFLGDQVZNTOWYHXUSPAIBRCJ", pos_in=0; valid din='A' dec=0.
  - Response: done 2 cycles later, dout='E'.
- Forward at pos 1: same wiring, pos_in=1; din='A' dec=0 -> dout='J'.
- Inverse at pos 0:
  - din='E' dec=1 -> dout='A' at 2 cycles.
  - din='J' dec=1 -> dout='Z' at 27 cycles; busy high throughout.
- Step, carry and wrap:
  - notch_in=16, pos_in=16; step -> pos=17, carry pulses once.
  - pos_in=25; step -> pos=0, no carry.
- Step during busy:
  - step issued during an inverse search -> pos unchanged until done.
  - Then pos+1; a second step while pending is dropped.
- Abort and error:
  - set during SRCH -> no done, state IDLE.
  - All-'A' wiring, din='B' dec=1 -> dout=8'h3F, err=1.
  - reset mid-search -> all outputs 0.
